l1_tl_c_arbiter: RTL and testbench

Two-requester arbiter that shares the L1 data cache's single TileLink C channel between the probe responder (ProbeAck/ProbeAckData) and the writeback unit (Release/ReleaseData). It is zero-latency combinational on the data path. It keeps a multi-beat message atomic on the channel and holds a presented message stable until it is accepted. It sits between the dcache's internal C sources and `tl_c_*` at the cache boundary.

---
 rtl/l1_tl_c_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_l1_tl_c_arbiter.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_tl_c_arbiter.sv
// l1_tl_c_arbiter: shares the dcache TileLink C channel between the probe responder (bit 0) and the writeback unit (bit 1).
// Latency: zero-cycle combinational valid/ready/field mux; the HOLD/BURST lock registers on the stalling/accepting edge.
// Backpressure: c_ready_i feeds only the owner's ready; a stalled or multi-beat message keeps the grant until its last beat.
// Build option: define L1_C_ARB_RR_EN for round-robin tie-breaking in IDLE (default build uses fixed probe priority).
module l1_tl_c_arbiter #(
    parameter int MAX_SIZE = 6
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p_valid_i,
    output logic        p_ready_o,
    input  logic [2:0]  p_opcode_i,
    input  logic [2:0]  p_param_i,
    input  logic [3:0]  p_size_i,
    input  logic [3:0]  p_source_i,
    input  logic [63:0] p_address_i,
    input  logic [63:0] p_data_i,
    input  logic        p_corrupt_i,

    input  logic        r_valid_i,
    output logic        r_ready_o,
    input  logic [2:0]  r_opcode_i,
    input  logic [2:0]  r_param_i,
    input  logic [3:0]  r_size_i,
    input  logic [3:0]  r_source_i,
    input  logic [63:0] r_address_i,
    input  logic [63:0] r_data_i,
    input  logic        r_corrupt_i,

    output logic        c_valid_o,
    input  logic        c_ready_i,
    output logic [2:0]  c_opcode_o,
    output logic [2:0]  c_param_o,
    output logic [3:0]  c_size_o,
    output logic [3:0]  c_source_o,
    output logic [63:0] c_address_o,
    output logic [63:0] c_data_o,
    output logic        c_corrupt_o,

    output logic [1:0]  grant_o,
    output logic        busy_o
);

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [3:0]  source;
        logic [63:0] address;
        logic [63:0] data;
        logic        corrupt;
    } c_msg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_owner;
    logic       w_owner_nxt;
    logic [2:0] r_beats_left;
    logic [2:0] w_beats_left_nxt;

    c_msg_t     w_p_msg;
    c_msg_t     w_r_msg;
    c_msg_t     w_sel_msg;
    c_msg_t     w_out_msg;
    logic       w_sel;       // 0 = probe responder, 1 = writeback unit
    logic       w_sel_vld;
    logic       w_fire;
    logic       w_done;      // final beat of a message accepted this cycle
    logic [3:0] w_beats;
    logic [1:0] w_grant;

`ifdef L1_C_ARB_RR_EN
    logic       r_rr_last;   // last completed owner; the other side wins the next tie
`endif

    // Beats in a message, judged from its first beat. The bus carries 8 bytes per beat,
    // so sizes above MAX_SIZE clamp and MAX_SIZE must stay at or below 6 (8 beats).
    function automatic logic [3:0] beat_count(input logic [2:0] opcode, input logic [3:0] size);
        logic [3:0] eff;
        beat_count = 4'd1;
        eff        = (size > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : size;
        if (opcode[0] && (size > 4'd3)) begin
            beat_count = 4'd1 << (eff - 4'd3);
        end
    endfunction

    assign w_p_msg = {p_opcode_i, p_param_i, p_size_i, p_source_i, p_address_i, p_data_i, p_corrupt_i};
    assign w_r_msg = {r_opcode_i, r_param_i, r_size_i, r_source_i, r_address_i, r_data_i, r_corrupt_i};

    // Owner selection: locked owner in HOLD/BURST, otherwise arbitrate on the live valids.
    always_comb begin
        w_sel = 1'b0;
        if (r_state != ST_IDLE) begin
            w_sel = r_owner;
        end else if (p_valid_i && r_valid_i) begin
`ifdef L1_C_ARB_RR_EN
            w_sel = ~r_rr_last;
`else
            w_sel = 1'b0;
`endif
        end else begin
            w_sel = r_valid_i;
        end
    end

    assign w_sel_vld = w_sel ? r_valid_i : p_valid_i;
    assign w_sel_msg = w_sel ? w_r_msg : w_p_msg;
    assign w_fire    = w_sel_vld & c_ready_i;
    assign w_beats   = beat_count(w_sel_msg.opcode, w_sel_msg.size);
    // A locked owner keeps its grant even while its valid is low mid-burst.
    assign w_grant   = ((r_state != ST_IDLE) || w_sel_vld) ? {w_sel, ~w_sel} : 2'b00;

    // Next-state: lock on a stall or on an accepted first beat of a multi-beat message.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_beats_left_nxt = r_beats_left;
        w_done           = 1'b0;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_fire) begin
                    if (w_beats > 4'd1) begin
                        w_state_nxt      = ST_BURST;
                        w_owner_nxt      = w_sel;
                        w_beats_left_nxt = 3'(w_beats - 4'd1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                    end
                end else if (w_sel_vld) begin
                    w_state_nxt = ST_HOLD;
                    w_owner_nxt = w_sel;
                end
            end
            ST_BURST: begin
                if (w_fire) begin
                    w_beats_left_nxt = r_beats_left - 3'd1;
                    if (r_beats_left == 3'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, owner and remaining-beat registers; reset abandons any burst.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_beats_left <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_beats_left <= w_beats_left_nxt;
        end
    end

`ifdef L1_C_ARB_RR_EN
    // Round-robin pointer follows the owner of each completed message; starts on writeback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_last <= 1'b1;
        end else if (w_done) begin
            r_rr_last <= w_sel;
        end
    end
`endif

    // Everything visible is forced low while reset is held.
    assign w_out_msg   = rst_n ? w_sel_msg : '0;
    assign c_valid_o   = rst_n & w_sel_vld;
    assign grant_o     = rst_n ? w_grant : 2'b00;
    assign p_ready_o   = rst_n & w_grant[0] & c_ready_i;
    assign r_ready_o   = rst_n & w_grant[1] & c_ready_i;
    assign busy_o      = rst_n & (r_state != ST_IDLE);

    assign c_opcode_o  = w_out_msg.opcode;
    assign c_param_o   = w_out_msg.param;
    assign c_size_o    = w_out_msg.size;
    assign c_source_o  = w_out_msg.source;
    assign c_address_o = w_out_msg.address;
    assign c_data_o    = w_out_msg.data;
    assign c_corrupt_o = w_out_msg.corrupt;

endmodule

// File: tb/tb_l1_tl_c_arbiter.sv
// tb_l1_tl_c_arbiter: directed scenarios plus randomized traffic against a message-level reference model.
// Latency: expected outputs are evaluated 2 time units after each rising edge, inputs driven 1 unit after it.
// Backpressure: requesters keep valid and fields stable until a beat is accepted; gaps only between beats.
`timescale 1ns/1ps
module tb_l1_tl_c_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        p_valid_i, p_ready_o, p_corrupt_i;
    logic [2:0]  p_opcode_i, p_param_i;
    logic [3:0]  p_size_i, p_source_i;
    logic [63:0] p_address_i, p_data_i;
    logic        r_valid_i, r_ready_o, r_corrupt_i;
    logic [2:0]  r_opcode_i, r_param_i;
    logic [3:0]  r_size_i, r_source_i;
    logic [63:0] r_address_i, r_data_i;
    logic        c_valid_o, c_ready_i, c_corrupt_o;
    logic [2:0]  c_opcode_o, c_param_o;
    logic [3:0]  c_size_o, c_source_o;
    logic [63:0] c_address_o, c_data_o;
    logic [1:0]  grant_o;
    logic        busy_o;

    l1_tl_c_arbiter #(.MAX_SIZE(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid_i(p_valid_i), .p_ready_o(p_ready_o), .p_opcode_i(p_opcode_i), .p_param_i(p_param_i),
        .p_size_i(p_size_i), .p_source_i(p_source_i), .p_address_i(p_address_i), .p_data_i(p_data_i),
        .p_corrupt_i(p_corrupt_i),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_opcode_i(r_opcode_i), .r_param_i(r_param_i),
        .r_size_i(r_size_i), .r_source_i(r_source_i), .r_address_i(r_address_i), .r_data_i(r_data_i),
        .r_corrupt_i(r_corrupt_i),
        .c_valid_o(c_valid_o), .c_ready_i(c_ready_i), .c_opcode_o(c_opcode_o), .c_param_o(c_param_o),
        .c_size_o(c_size_o), .c_source_o(c_source_o), .c_address_o(c_address_o), .c_data_o(c_data_o),
        .c_corrupt_o(c_corrupt_o),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [3:0]  src;
        logic [63:0] addr;
        logic [63:0] data0;
        logic        cor;
    } msg_t;

    // Requester-side state: pending messages, beat index within the head message.
    msg_t pq[$];
    msg_t rq[$];
    int   pbeat, rbeat, p_block, r_block;
    bit   p_on, r_on;
    int   gap_pct, rdy_pct;
    logic rst_req;

    // Reference model: which side holds the channel and how many beats it still owes.
    bit   m_lock, m_owner, m_last, m_cur;
    int   m_left;
    logic e_cv, e_pr, e_rr, e_busy, e_show;
    logic [1:0]   e_grant;
    logic [142:0] e_fld;
    logic [2:0]   e_op;
    logic [3:0]   e_sz;

    int n_checks = 0;
    int n_fails  = 0;

    function automatic int nbeats(input logic [2:0] op, input logic [3:0] size);
        int s;
        if (!op[0] || size <= 4'd3) return 1;
        s = (size > 4'd6) ? 6 : int'(size);
        return 1 << (s - 3);
    endfunction

    function automatic msg_t mk(input logic [2:0] op, input logic [3:0] size,
                                input logic [63:0] addr, input logic [63:0] d0);
        msg_t m;
        m.op = op; m.size = size; m.addr = addr; m.data0 = d0;
        m.param = 3'($urandom); m.src = 4'($urandom); m.cor = 1'($urandom);
        return m;
    endfunction

    // Later beats carry junk opcode/size that the arbiter must not count with.
    function automatic logic [142:0] beat_fields(input msg_t m, input int beat);
        logic [2:0] op;
        logic [3:0] sz;
        op = (beat == 0) ? m.op : {m.op[2:1], ~m.op[0]};
        sz = (beat == 0) ? m.size : 4'(15 - beat);
        return {op, m.param, sz, m.src, m.addr, m.data0 + 64'(beat), m.cor};
    endfunction

    function automatic logic [142:0] dut_fld();
        return {c_opcode_o, c_param_o, c_size_o, c_source_o, c_address_o, c_data_o, c_corrupt_o};
    endfunction

    function automatic logic [148:0] obs_vec();
        return {c_valid_o, p_ready_o, r_ready_o, grant_o, busy_o, e_show ? dut_fld() : 143'd0};
    endfunction

    function automatic logic [148:0] exp_vec();
        return {e_cv, e_pr, e_rr, e_grant, e_busy, e_show ? e_fld : 143'd0};
    endfunction

    task automatic drive();
        logic [142:0] f;
        rst_n     = rst_req;
        c_ready_i = ($urandom_range(99) < rdy_pct);
        if (!p_on && pq.size() > 0) begin
            if (p_block > 0) p_block--;
            else if ($urandom_range(99) >= gap_pct) p_on = 1'b1;
        end
        if (!r_on && rq.size() > 0) begin
            if (r_block > 0) r_block--;
            else if ($urandom_range(99) >= gap_pct) r_on = 1'b1;
        end
        p_valid_i = p_on;
        r_valid_i = r_on;
        f = (pq.size() > 0) ? beat_fields(pq[0], pbeat) : 143'({$urandom, $urandom, $urandom, $urandom, $urandom});
        {p_opcode_i, p_param_i, p_size_i, p_source_i, p_address_i, p_data_i, p_corrupt_i} = f;
        f = (rq.size() > 0) ? beat_fields(rq[0], rbeat) : 143'({$urandom, $urandom, $urandom, $urandom, $urandom});
        {r_opcode_i, r_param_i, r_size_i, r_source_i, r_address_i, r_data_i, r_corrupt_i} = f;
    endtask

    task automatic eval_model();
        bit own;
        own = 1'b0;
        e_cv = 0; e_pr = 0; e_rr = 0; e_grant = 2'b00; e_busy = 0; e_fld = '0; e_show = 1'b1;
        if (rst_n) begin
            if (m_lock) begin
                own = m_owner; e_busy = 1'b1; e_cv = own ? r_valid_i : p_valid_i;
                e_grant = own ? 2'b10 : 2'b01;
            end else if (p_valid_i || r_valid_i) begin
                if (p_valid_i && r_valid_i) begin
`ifdef L1_C_ARB_RR_EN
                    own = !m_last;
`else
                    own = 1'b0;
`endif
                end else begin
                    own = r_valid_i;
                end
                e_cv = 1'b1; e_grant = own ? 2'b10 : 2'b01;
            end
            e_pr   = e_grant[0] & c_ready_i;
            e_rr   = e_grant[1] & c_ready_i;
            e_fld  = own ? {r_opcode_i, r_param_i, r_size_i, r_source_i, r_address_i, r_data_i, r_corrupt_i}
                         : {p_opcode_i, p_param_i, p_size_i, p_source_i, p_address_i, p_data_i, p_corrupt_i};
            e_op   = own ? r_opcode_i : p_opcode_i;
            e_sz   = own ? r_size_i : p_size_i;
            e_show = e_cv;
        end
        m_cur = own;
    endtask

    // Advance model and requesters by the clock edge that ends this cycle.
    task automatic commit();
        int n;
        if (!rst_n) begin
            m_lock = 0; m_owner = 0; m_left = 0; m_last = 1'b1;
            pq.delete(); rq.delete();
            pbeat = 0; rbeat = 0; p_on = 0; r_on = 0; p_block = 0; r_block = 0;
            return;
        end
        if (!e_cv) return;
        if (c_ready_i) begin
            if (m_lock) begin
                m_left--;
                if (m_left == 0) begin m_lock = 0; m_last = m_cur; end
            end else begin
                n = nbeats(e_op, e_sz);
                if (n > 1) begin m_lock = 1; m_owner = m_cur; m_left = n - 1; end
                else m_last = m_cur;
            end
            if (m_cur == 1'b0) begin
                p_on = 0; pbeat++;
                if (pbeat == nbeats(pq[0].op, pq[0].size)) begin void'(pq.pop_front()); pbeat = 0; end
            end else begin
                r_on = 0; rbeat++;
                if (rbeat == nbeats(rq[0].op, rq[0].size)) begin void'(rq.pop_front()); rbeat = 0; end
            end
        end else if (!m_lock) begin
            m_lock = 1; m_owner = m_cur; m_left = nbeats(e_op, e_sz);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        #1;
        eval_model();
    endtask

    task automatic do_reset();
        rst_req = 1'b0; gap_pct = 0; rdy_pct = 100;
        tick();
        commit();
        rst_req = 1'b1;
    endtask

    task automatic test_reset();
        rst_req = 1'b0;
        for (int cyc = 1; cyc <= 2; cyc++) begin
            tick();
            p_valid_i = 1'b1; r_valid_i = 1'b1; c_ready_i = 1'b1;
            #1;
            n_checks++;
            if ({c_valid_o, p_ready_o, r_ready_o, grant_o, busy_o, dut_fld()} !== 149'd0) begin
                n_fails++;
                $display("FAIL reset_outputs cyc %0d got %h expected all zero", cyc,
                         {c_valid_o, p_ready_o, r_ready_o, grant_o, busy_o, dut_fld()});
            end
            eval_model();
            commit();
        end
        rst_req = 1'b1;
        tick();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fails++; $display("FAIL reset_idle got %h expected %h", obs_vec(), exp_vec());
        end
        commit();
    endtask

    task automatic test_single_probeack();
        do_reset();
        pq.push_back(mk(3'd4, 4'd6, 64'h1000, 64'h0));
        tick();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fails++; $display("FAIL single_model got %h expected %h", obs_vec(), exp_vec());
        end
        n_checks++;
        if ({c_valid_o, p_ready_o, c_opcode_o, grant_o, c_address_o} !== {1'b1, 1'b1, 3'd4, 2'b01, 64'h1000}) begin
            n_fails++;
            $display("FAIL single_fields got v=%b rdy=%b op=%0d grant=%b addr=%h expected v=1 rdy=1 op=4 grant=01 addr=1000",
                     c_valid_o, p_ready_o, c_opcode_o, grant_o, c_address_o);
        end
        commit();
        tick();
        n_checks++;
        if ({busy_o, c_valid_o, grant_o} !== 4'b0000) begin
            n_fails++; $display("FAIL single_no_burst got busy=%b v=%b grant=%b expected 0 0 00", busy_o, c_valid_o, grant_o);
        end
        commit();
    endtask

    task automatic test_probe_data_burst();
        int acc_own[$];
        int acc_cyc[$];
        logic [63:0] acc_dat[$];
        do_reset();
        pq.push_back(mk(3'd5, 4'd6, 64'h2000, 64'd0));
        rq.push_back(mk(3'd7, 4'd6, 64'h3000, 64'd100));
        for (int cyc = 1; cyc <= 18; cyc++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fails++; $display("FAIL pad_burst cyc %0d got %h expected %h", cyc, obs_vec(), exp_vec());
            end
            if (c_valid_o && c_ready_i) begin
                acc_own.push_back(grant_o == 2'b10 ? 1 : 0); acc_cyc.push_back(cyc); acc_dat.push_back(c_data_o);
            end
            commit();
        end
        n_checks++;
        if (acc_own.size() != 16) begin
            n_fails++; $display("FAIL pad_burst_count got %0d beats expected 16", acc_own.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if ({acc_own[i], acc_cyc[i], acc_dat[i]} !== {((i < 8) ? 0 : 1), i + 1, ((i < 8) ? 64'(i) : 64'd100)}) begin
                    n_fails++;
                    $display("FAIL pad_burst_beat %0d got owner=%0d cyc=%0d data=%0d expected owner=%0d cyc=%0d data=%0d",
                             i, acc_own[i], acc_cyc[i], acc_dat[i], (i < 8) ? 0 : 1, i + 1, (i < 8) ? i : 100);
                end
            end
        end
    endtask

    task automatic test_hold();
        int acc_own[$];
        int acc_cyc[$];
        logic [63:0] acc_dat[$];
        do_reset();
        rq.push_back(mk(3'd7, 4'd6, 64'h4000, 64'd200));
        rdy_pct = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (cyc == 2) pq.push_back(mk(3'd4, 4'd6, 64'h5000, 64'd0));
            if (cyc == 4) rdy_pct = 100;
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fails++; $display("FAIL hold cyc %0d got %h expected %h", cyc, obs_vec(), exp_vec());
            end
            if (cyc <= 3) begin
                n_checks++;
                if ({grant_o, c_data_o, p_ready_o} !== {2'b10, 64'd200, 1'b0}) begin
                    n_fails++;
                    $display("FAIL hold_lock cyc %0d got grant=%b data=%0d p_rdy=%b expected 10 200 0", cyc, grant_o, c_data_o, p_ready_o);
                end
            end
            if (c_valid_o && c_ready_i) begin
                acc_own.push_back(grant_o == 2'b10 ? 1 : 0); acc_cyc.push_back(cyc); acc_dat.push_back(c_data_o);
            end
            commit();
        end
        n_checks++;
        if (acc_own.size() != 9) begin
            n_fails++; $display("FAIL hold_count got %0d beats expected 9", acc_own.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if ({acc_own[i], acc_cyc[i]} !== {((i < 8) ? 1 : 0), ((i < 8) ? i + 4 : 12)} ||
                    (i < 8 && acc_dat[i] !== 64'(200 + i))) begin
                    n_fails++;
                    $display("FAIL hold_beat %0d got owner=%0d cyc=%0d data=%0d expected owner=%0d cyc=%0d",
                             i, acc_own[i], acc_cyc[i], acc_dat[i], (i < 8) ? 1 : 0, (i < 8) ? i + 4 : 12);
                end
            end
        end
    endtask

    task automatic test_tie();
        int acc_own[$];
        int exp_own;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pq.push_back(mk(3'd4, 4'($urandom_range(15)), 64'(i), 64'(i)));
            rq.push_back(mk(3'd6, 4'($urandom_range(15)), 64'(i), 64'(i)));
        end
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fails++; $display("FAIL tie cyc %0d got %h expected %h", cyc, obs_vec(), exp_vec());
            end
            if (c_valid_o && c_ready_i) acc_own.push_back(grant_o == 2'b10 ? 1 : 0);
            commit();
        end
        n_checks++;
        if (acc_own.size() != 8) begin
            n_fails++; $display("FAIL tie_count got %0d messages expected 8", acc_own.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
`ifdef L1_C_ARB_RR_EN
                exp_own = i % 2;
`else
                exp_own = (i < 4) ? 0 : 1;
`endif
                n_checks++;
                if (acc_own[i] != exp_own) begin
                    n_fails++; $display("FAIL tie_order %0d got owner=%0d expected owner=%0d", i, acc_own[i], exp_own);
                end
            end
        end
    endtask

    task automatic test_burst_gap();
        int acc_cyc[$];
        logic [63:0] acc_dat[$];
        bit gapped;
        gapped = 1'b0;
        do_reset();
        rq.push_back(mk(3'd7, 4'd6, 64'h6000, 64'd300));
        for (int cyc = 1; cyc <= 13; cyc++) begin
            if (rbeat == 4 && !gapped) begin
                gapped = 1'b1; r_block = 2;
                pq.push_back(mk(3'd4, 4'd0, 64'h7000, 64'd0));
            end
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fails++; $display("FAIL burst_gap cyc %0d got %h expected %h", cyc, obs_vec(), exp_vec());
            end
            if (cyc == 5 || cyc == 6) begin
                n_checks++;
                if ({c_valid_o, grant_o, p_ready_o, busy_o} !== {1'b0, 2'b10, 1'b0, 1'b1}) begin
                    n_fails++;
                    $display("FAIL burst_gap_lock cyc %0d got v=%b grant=%b p_rdy=%b busy=%b expected 0 10 0 1",
                             cyc, c_valid_o, grant_o, p_ready_o, busy_o);
                end
            end
            if (c_valid_o && c_ready_i) begin acc_cyc.push_back(cyc); acc_dat.push_back(c_data_o); end
            commit();
        end
        n_checks++;
        if (acc_cyc.size() != 9) begin
            n_fails++; $display("FAIL burst_gap_count got %0d beats expected 9", acc_cyc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if ({acc_cyc[i], acc_dat[i]} !== {((i < 4) ? i + 1 : i + 3), 64'(300 + i)}) begin
                    n_fails++;
                    $display("FAIL burst_gap_beat %0d got cyc=%0d data=%0d expected cyc=%0d data=%0d",
                             i, acc_cyc[i], acc_dat[i], (i < 4) ? i + 1 : i + 3, 300 + i);
                end
            end
            n_checks++;
            if (acc_cyc[8] != 11) begin
                n_fails++; $display("FAIL burst_gap_probe got cyc=%0d expected cyc=11", acc_cyc[8]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int acc_n;
        acc_n = 0;
        do_reset();
        rq.push_back(mk(3'd7, 4'd6, 64'h8000, 64'd400));
        for (int cyc = 1; cyc <= 5; cyc++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fails++; $display("FAIL reset_mid cyc %0d got %h expected %h", cyc, obs_vec(), exp_vec());
            end
            if (c_valid_o && c_ready_i) acc_n++;
            commit();
        end
        n_checks++;
        if (acc_n != 5) begin
            n_fails++; $display("FAIL reset_mid_pre got %0d beats expected 5", acc_n);
        end
        rst_req = 1'b0;
        for (int cyc = 6; cyc <= 7; cyc++) begin
            tick();
            n_checks++;
            if ({c_valid_o, p_ready_o, r_ready_o, grant_o, busy_o, dut_fld()} !== 149'd0) begin
                n_fails++; $display("FAIL reset_mid_zero cyc %0d got %h expected all zero", cyc,
                                    {c_valid_o, p_ready_o, r_ready_o, grant_o, busy_o, dut_fld()});
            end
            commit();
        end
        rst_req = 1'b1;
        pq.push_back(mk(3'd4, 4'd6, 64'h9000, 64'd0));
        tick();
        n_checks++;
        if ({c_valid_o, p_ready_o, grant_o, busy_o, c_opcode_o, c_address_o} !== {1'b1, 1'b1, 2'b01, 1'b0, 3'd4, 64'h9000}) begin
            n_fails++;
            $display("FAIL reset_mid_probe got v=%b rdy=%b grant=%b busy=%b op=%0d addr=%h expected 1 1 01 0 4 9000",
                     c_valid_o, p_ready_o, grant_o, busy_o, c_opcode_o, c_address_o);
        end
        commit();
        tick();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fails++; $display("FAIL reset_mid_after got %h expected %h", obs_vec(), exp_vec());
        end
        commit();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (cyc % 200 == 1) begin
                rdy_pct = int'($urandom_range(100, 20));
                gap_pct = int'($urandom_range(60, 0));
            end
            if (pq.size() < 3 && $urandom_range(3) == 0)
                pq.push_back(mk(($urandom_range(1) != 0) ? 3'd5 : 3'd4, 4'($urandom_range(15)),
                                {$urandom, $urandom}, {$urandom, $urandom}));
            if (rq.size() < 3 && $urandom_range(3) == 0)
                rq.push_back(mk(($urandom_range(1) != 0) ? 3'd7 : 3'd6, 4'($urandom_range(15)),
                                {$urandom, $urandom}, {$urandom, $urandom}));
            rst_req = ($urandom_range(499) != 0);
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fails++; $display("FAIL random cyc %0d got %h expected %h", cyc, obs_vec(), exp_vec());
            end
            commit();
        end
        rst_req = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_req = 1'b0; rst_n = 1'b0; gap_pct = 0; rdy_pct = 100;
        p_on = 0; r_on = 0; pbeat = 0; rbeat = 0; p_block = 0; r_block = 0;
        m_lock = 0; m_owner = 0; m_left = 0; m_last = 1'b1; m_cur = 0;
        p_valid_i = 0; r_valid_i = 0; c_ready_i = 0;
        {p_opcode_i, p_param_i, p_size_i, p_source_i, p_address_i, p_data_i, p_corrupt_i} = '0;
        {r_opcode_i, r_param_i, r_size_i, r_source_i, r_address_i, r_data_i, r_corrupt_i} = '0;
        test_reset();
        test_single_probeack();
        test_probe_data_burst();
        test_hold();
        test_tie();
        test_burst_gap();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
